decode_stage: RTL and testbench

Parametrised, handshaked successor to the single-phase decoder. It decodes RV32I (optionally RV32M) instructions from fetch into immediate, register selects, ALU function and the decoded-op word. Results go into a 2-entry output buffer with valid/ready flow control. A register scoreboard holds back instructions that read the destination of an outstanding LOAD. It sits between fetch/register-file read and execute, and replaces the `phase_decode` enable scheme with back-pressure.

---
 rtl/decode_stage.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: handshaked decoder feeding a 2-entry output FIFO, with a load-use scoreboard.
// Optional RV32M decode is enabled by defining DECODE_STAGE_MEXT_EN. OPLEN must be at least 14.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int OPLEN = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  curr_pc_fd,
    input  logic [XLEN-1:0]  next_pc_fd,
    output logic [4:0]       rs1sel,
    output logic [4:0]       rs2sel,
    input  logic [XLEN-1:0]  rs1data_rd,
    input  logic [XLEN-1:0]  rs2data_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  rs1data_de,
    output logic [XLEN-1:0]  rs2data_de,
    output logic [XLEN-1:0]  curr_pc_de,
    output logic [XLEN-1:0]  next_pc_de,
    output logic [4:0]       funct_alu,
    output logic [4:0]       rdsel_de,
    output logic [OPLEN-1:0] decoded_op_de,
    input  logic             ld_done_valid,
    input  logic [4:0]       ld_done_rd,
    input  logic             flush
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] USE_RD_ALU  = 2'd0;
    localparam logic [1:0] USE_RD_MEM  = 2'd1;
    localparam logic [1:0] USE_RD_PC4  = 2'd2;
    localparam logic [2:0] FUNCT3_JUMP = 3'b010;

    // Decoded-op word layout
    localparam int F_USE_RS1 = 0;
    localparam int F_USE_RS2 = 1;
    localparam int F_RDSEL   = 2;   // 2 bits
    localparam int F_FUNCT3  = 4;   // 3 bits
    localparam int F_JUMP    = 7;
    localparam int F_BRANCH  = 8;
    localparam int F_MEM_WE  = 9;
    localparam int F_MEM_RD  = 10;
    localparam int F_SRC_IMM = 11;
    localparam int F_SRC_PC  = 12;
    localparam int F_ILLEGAL = 13;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [XLEN-1:0]  cpc;
        logic [XLEN-1:0]  npc;
`ifdef DECODE_STAGE_MEXT_EN
        logic             m_sel;
`endif
        logic [3:0]       alu_f;
        logic [4:0]       rd;
        logic [OPLEN-1:0] op;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    logic             use_rs1, use_rs2, jump_en, branch_en, mem_we, mem_rd;
    logic             src_imm, src_pc, illegal;
    logic [1:0]       rd_sel;
    logic [2:0]       f3_dec;
    logic [3:0]       alu_f;
    logic [4:0]       dec_rd;
    logic [XLEN-1:0]  dec_imm;
    logic [OPLEN-1:0] dec_op;
`ifdef DECODE_STAGE_MEXT_EN
    logic             m_sel;
`endif

    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        jump_en   = 1'b0;
        branch_en = 1'b0;
        mem_we    = 1'b0;
        mem_rd    = 1'b0;
        src_imm   = 1'b0;
        src_pc    = 1'b0;
        illegal   = 1'b0;
        rd_sel    = USE_RD_ALU;
        f3_dec    = 3'b000;
        alu_f     = 4'b0000;
        dec_rd    = inst[11:7];
        dec_imm   = '0;
`ifdef DECODE_STAGE_MEXT_EN
        m_sel     = 1'b0;
`endif
        case (opcode)
            OPC_LUI: begin
                src_imm = 1'b1;
                dec_imm = imm_u;
            end
            OPC_AUIPC: begin
                src_imm = 1'b1;
                src_pc  = 1'b1;
                dec_imm = imm_u;
            end
            OPC_JAL: begin
                jump_en = 1'b1;
                f3_dec  = FUNCT3_JUMP;
                rd_sel  = USE_RD_PC4;
                src_imm = 1'b1;
                src_pc  = 1'b1;
                dec_imm = imm_j;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1;
                jump_en = 1'b1;
                f3_dec  = FUNCT3_JUMP;
                rd_sel  = USE_RD_PC4;
                src_imm = 1'b1;
                dec_imm = imm_i;
            end
            OPC_BRANCH: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                branch_en = 1'b1;
                f3_dec    = funct3;
                dec_rd    = 5'd0;
                dec_imm   = imm_b;
                illegal   = (funct3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1;
                mem_rd  = 1'b1;
                rd_sel  = USE_RD_MEM;
                f3_dec  = funct3;
                src_imm = 1'b1;
                dec_imm = imm_i;
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                mem_we  = 1'b1;
                f3_dec  = funct3;
                src_imm = 1'b1;
                dec_rd  = 5'd0;
                dec_imm = imm_s;
            end
            OPC_OPIMM: begin
                use_rs1 = 1'b1;
                src_imm = 1'b1;
                f3_dec  = funct3;
                dec_imm = imm_i;
                // inst[30] only selects SRAI; for other funct3 it is immediate data
                alu_f   = {(funct3 == 3'b101) & inst[30], funct3};
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                f3_dec  = funct3;
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    alu_f = {inst[30], funct3};
                end else if (funct7 == 7'b0000001) begin
`ifdef DECODE_STAGE_MEXT_EN
                    m_sel = 1'b1;
                    alu_f = {1'b0, funct3};
`else
                    illegal = 1'b1;
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        dec_op                  = '0;
        dec_op[F_USE_RS1]       = use_rs1;
        dec_op[F_USE_RS2]       = use_rs2;
        dec_op[F_RDSEL +: 2]    = rd_sel;
        dec_op[F_FUNCT3 +: 3]   = f3_dec;
        dec_op[F_JUMP]          = jump_en;
        dec_op[F_BRANCH]        = branch_en;
        dec_op[F_MEM_WE]        = mem_we;
        dec_op[F_MEM_RD]        = mem_rd;
        dec_op[F_SRC_IMM]       = src_imm;
        dec_op[F_SRC_PC]        = src_pc;

        // Illegal entries carry only the flag so execute cannot act on stale fields
        if (illegal) begin
            use_rs1           = 1'b0;
            use_rs2           = 1'b0;
            mem_rd            = 1'b0;
            dec_rd            = 5'd0;
            dec_imm           = '0;
            alu_f             = 4'b0000;
            dec_op            = '0;
            dec_op[F_ILLEGAL] = 1'b1;
`ifdef DECODE_STAGE_MEXT_EN
            m_sel             = 1'b0;
`endif
        end
    end

    assign rs1sel = (opcode == OPC_LUI) ? 5'd0 : inst[19:15];
    assign rs2sel = inst[24:20];

    logic [31:0] busy_q, busy_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d, tail_q, tail_d;
    logic        hazard, acc, pop;
    entry_t      entry_q [2];
    entry_t      entry_d, head;

    assign hazard    = (use_rs1 & busy_q[rs1sel]) | (use_rs2 & busy_q[rs2sel]);
    assign in_ready  = ((count_q < 2'd2) | ((count_q == 2'd2) & out_ready)) & ~hazard & ~flush;
    assign acc       = in_valid & in_ready;
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid & out_ready;

    always_comb begin
        entry_d       = '0;
        entry_d.imm   = dec_imm;
        entry_d.rs1   = rs1data_rd;
        entry_d.rs2   = rs2data_rd;
        entry_d.cpc   = curr_pc_fd;
        entry_d.npc   = next_pc_fd;
        entry_d.alu_f = alu_f;
        entry_d.rd    = dec_rd;
        entry_d.op    = dec_op;
`ifdef DECODE_STAGE_MEXT_EN
        entry_d.m_sel = m_sel;
`endif
    end

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            if (acc) tail_d = ~tail_q;
            if (pop) head_d = ~head_q;
            count_d = count_q + 2'(acc) - 2'(pop);
        end
    end

    // Set after clear so a same-cycle new load to the same rd stays busy
    always_comb begin
        busy_d = busy_q;
        if (ld_done_valid) busy_d[ld_done_rd] = 1'b0;
        if (acc && mem_rd && dec_rd != 5'd0) busy_d[dec_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            busy_q  <= '0;
            for (int i = 0; i < 2; i++) entry_q[i] <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            busy_q  <= busy_d;
            if (acc) entry_q[tail_q] <= entry_d;
        end
    end

    assign head          = entry_q[head_q];
    assign imm           = head.imm;
    assign rs1data_de    = head.rs1;
    assign rs2data_de    = head.rs2;
    assign curr_pc_de    = head.cpc;
    assign next_pc_de    = head.npc;
    assign rdsel_de      = head.rd;
    assign decoded_op_de = head.op;
`ifdef DECODE_STAGE_MEXT_EN
    assign funct_alu     = {head.m_sel, head.alu_f};
`else
    assign funct_alu     = {1'b0, head.alu_f};
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic, all checked against a queue/array model.
module tb_decode_stage;
    localparam int XLEN  = 32;
    localparam int OPLEN = 14;

    localparam logic [31:0] I_ADDI_X1  = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_ADD_X2   = 32'h00108133;  // add x2,x1,x1
    localparam logic [31:0] I_LW_X3    = 32'h00002183;  // lw x3,0(x0)
    localparam logic [31:0] I_ADD_X4   = 32'h00018233;  // add x4,x3,x0
    localparam logic [31:0] I_LW_X5    = 32'h00002283;  // lw x5,0(x0)
    localparam logic [31:0] I_ADD_X6   = 32'h00028333;  // add x6,x5,x0
    localparam logic [31:0] I_LW_X7    = 32'h00002383;  // lw x7,0(x0)
    localparam logic [31:0] I_ADD_X9   = 32'h000384B3;  // add x9,x7,x0
    localparam logic [31:0] I_LUI_X10  = 32'h12345537;  // lui x10,0x12345
    localparam logic [31:0] I_MUL_X8   = 32'h02208433;  // mul x8,x1,x2

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0, in_ready;
    logic [31:0]      inst = '0;
    logic [XLEN-1:0]  curr_pc_fd = '0, next_pc_fd = '0, rs1data_rd = '0, rs2data_rd = '0;
    logic [4:0]       rs1sel, rs2sel, funct_alu, rdsel_de;
    logic             out_valid, out_ready = 1'b0;
    logic [XLEN-1:0]  imm, rs1data_de, rs2data_de, curr_pc_de, next_pc_de;
    logic [OPLEN-1:0] decoded_op_de;
    logic             ld_done_valid = 1'b0;
    logic [4:0]       ld_done_rd = '0;
    logic             flush = 1'b0;

    decode_stage #(.XLEN(XLEN), .OPLEN(OPLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .curr_pc_fd(curr_pc_fd), .next_pc_fd(next_pc_fd), .rs1sel(rs1sel), .rs2sel(rs2sel),
        .rs1data_rd(rs1data_rd), .rs2data_rd(rs2data_rd), .out_valid(out_valid),
        .out_ready(out_ready), .imm(imm), .rs1data_de(rs1data_de), .rs2data_de(rs2data_de),
        .curr_pc_de(curr_pc_de), .next_pc_de(next_pc_de), .funct_alu(funct_alu),
        .rdsel_de(rdsel_de), .decoded_op_de(decoded_op_de), .ld_done_valid(ld_done_valid),
        .ld_done_rd(ld_done_rd), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm, rs1, rs2, cpc, npc;
        logic [4:0]  alu, rd;
        logic [13:0] op;
    } exp_t;

    exp_t q[$];
    bit   busy[32];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference decode: flags per opcode, immediates by signed arithmetic, op word by weighted sum
    function automatic void ref_decode(input logic [31:0] in, output exp_t e,
                                       output bit u1, output bit u2, output bit ld);
        int f3 = int'(in[14:12]);
        int f7 = int'(in[31:25]);
        int rds = 0, fsel = 0, jmp = 0, br = 0, we = 0, mrd = 0, simm = 0, spc = 0;
        int ill = 0, alu = 0, iv = 0, rd = int'(in[11:7]);
        u1 = 0; u2 = 0; ld = 0;
        case (in[6:0])
            7'h37: begin simm = 1; iv = int'({in[31:12], 12'h000}); end
            7'h17: begin simm = 1; spc = 1; iv = int'({in[31:12], 12'h000}); end
            7'h6f: begin jmp = 1; fsel = 2; rds = 2; spc = 1; simm = 1;
                         iv = $signed({in[31], in[19:12], in[20], in[30:21]}) * 2; end
            7'h67: begin u1 = 1; jmp = 1; fsel = 2; rds = 2; simm = 1; iv = $signed(in[31:20]); end
            7'h63: begin u1 = 1; u2 = 1; br = 1; fsel = f3; rd = 0;
                         iv = $signed({in[31], in[7], in[30:25], in[11:8]}) * 2;
                         ill = (f3 == 2 || f3 == 3) ? 1 : 0; end
            7'h03: begin u1 = 1; mrd = 1; rds = 1; fsel = f3; simm = 1; ld = 1;
                         iv = $signed(in[31:20]); end
            7'h23: begin u1 = 1; u2 = 1; we = 1; fsel = f3; simm = 1; rd = 0;
                         iv = $signed(in[31:25]) * 32 + int'(in[11:7]); end
            7'h13: begin u1 = 1; simm = 1; fsel = f3; iv = $signed(in[31:20]);
                         alu = f3 + ((f3 == 5 && in[30]) ? 8 : 0); end
            7'h33: begin
                u1 = 1; u2 = 1; fsel = f3;
                if (f7 == 0 || f7 == 32) alu = f3 + (in[30] ? 8 : 0);
`ifdef DECODE_STAGE_MEXT_EN
                else if (f7 == 1) alu = 16 + f3;
`endif
                else ill = 1;
            end
            default: ill = 1;
        endcase
        e.rs1 = '0; e.rs2 = '0; e.cpc = '0; e.npc = '0;
        if (ill != 0) begin
            u1 = 0; u2 = 0; ld = 0;
            e.imm = '0; e.alu = '0; e.rd = '0; e.op = 14'(1 << 13);
        end else begin
            e.imm = iv;
            e.alu = 5'(alu);
            e.rd  = 5'(rd);
            e.op  = 14'(u1 + u2 * 2 + rds * 4 + fsel * 16 + jmp * 128 + br * 256 + we * 512
                        + mrd * 1024 + simm * 2048 + spc * 4096);
        end
    endfunction

    // One clock: drive at negedge, compare at negedge+1, advance model at posedge
    task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit ldv,
                        input logic [4:0] ldrd, input bit fl, input bit rs);
        exp_t e;
        bit u1, u2, ld, haz, exp_rdy;
        int cnt, s1, s2;
        @(negedge clk);
        in_valid = v; inst = ins; out_ready = ordy; ld_done_valid = ldv; ld_done_rd = ldrd;
        flush = fl; rst = rs;
        curr_pc_fd = $urandom; next_pc_fd = $urandom; rs1data_rd = $urandom; rs2data_rd = $urandom;
        #1;
        ref_decode(ins, e, u1, u2, ld);
        e.rs1 = rs1data_rd; e.rs2 = rs2data_rd; e.cpc = curr_pc_fd; e.npc = next_pc_fd;
        s1 = (ins[6:0] == 7'h37) ? 0 : int'(ins[19:15]);
        s2 = int'(ins[24:20]);
        haz = (u1 && busy[s1]) || (u2 && busy[s2]);
        cnt = q.size();
        exp_rdy = (cnt < 2 || ordy) && !haz && !fl;
        if (!rs) begin
            check_val("in_ready", in_ready, exp_rdy);
            check_val("out_valid", out_valid, cnt != 0);
            check_val("rs1sel", rs1sel, s1);
            check_val("rs2sel", rs2sel, s2);
            if (cnt != 0) begin
                check_val("imm", imm, q[0].imm);
                check_val("rs1data_de", rs1data_de, q[0].rs1);
                check_val("rs2data_de", rs2data_de, q[0].rs2);
                check_val("curr_pc_de", curr_pc_de, q[0].cpc);
                check_val("next_pc_de", next_pc_de, q[0].npc);
                check_val("funct_alu", funct_alu, q[0].alu);
                check_val("rdsel_de", rdsel_de, q[0].rd);
                check_val("decoded_op", decoded_op_de, q[0].op);
            end
        end
        @(posedge clk);
        if (rs) begin
            q.delete();
            foreach (busy[i]) busy[i] = 0;
        end else begin
            if (fl) q.delete();
            else begin
                if (cnt != 0 && ordy) void'(q.pop_front());
                if (v && exp_rdy) q.push_back(e);
            end
            if (ldv) busy[ldrd] = 0;
            if (v && exp_rdy && ld && e.rd != 0) busy[e.rd] = 1;
        end
    endtask

    task automatic drain();
        repeat (3) step(0, 32'h0, 1, 0, 5'd0, 0, 0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 11);
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        r[11:7]  = 5'($urandom_range(0, 7));
        case (k)
            0: r[6:0] = 7'h37;
            1: r[6:0] = 7'h17;
            2: r[6:0] = 7'h6f;
            3: r[6:0] = 7'h67;
            4: r[6:0] = 7'h63;
            5, 6: r[6:0] = 7'h03;
            7: r[6:0] = 7'h23;
            8: r[6:0] = 7'h13;
            9, 10: begin
                r[6:0] = 7'h33;
                case ($urandom_range(0, 3))
                    0: r[31:25] = 7'h00;
                    1: r[31:25] = 7'h20;
                    2: r[31:25] = 7'h01;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        // Reset: queue empty, outputs zero
        step(0, 32'h0, 0, 0, 5'd0, 0, 1);
        step(0, 32'h0, 0, 0, 5'd0, 0, 1);
        #2;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_imm", imm, 0);
        check_val("rst_rdsel", rdsel_de, 0);
        check_val("rst_op", decoded_op_de, 0);
        check_val("rst_funct_alu", funct_alu, 0);

        // Streaming addi / add
        step(1, I_ADDI_X1, 1, 0, 5'd0, 0, 0);
        #2;
        check_val("addi_imm", imm, 5);
        check_val("addi_rd", rdsel_de, 1);
        step(1, I_ADD_X2, 1, 0, 5'd0, 0, 0);
        #2;
        check_val("add_rd", rdsel_de, 2);
        check_val("add_alu", funct_alu, 0);
        drain();

        // Load-use stall released the cycle after ld_done
        step(1, I_LW_X3, 1, 0, 5'd0, 0, 0);
        repeat (3) step(1, I_ADD_X4, 1, 0, 5'd0, 0, 0);
        step(1, I_ADD_X4, 1, 1, 5'd3, 0, 0);
        step(1, I_ADD_X4, 1, 0, 5'd0, 0, 0);
        drain();

        // Back-pressure: full buffer, pop+push keeps two entries
        step(1, I_ADDI_X1, 0, 0, 5'd0, 0, 0);
        step(1, I_ADD_X2, 0, 0, 5'd0, 0, 0);
        step(1, I_LUI_X10, 0, 0, 5'd0, 0, 0);
        step(1, I_LUI_X10, 1, 0, 5'd0, 0, 0);
        step(0, 32'h0, 0, 0, 5'd0, 0, 0);
        drain();

        // Flush keeps scoreboard
        step(1, I_LW_X5, 0, 0, 5'd0, 0, 0);
        step(1, I_ADDI_X1, 0, 0, 5'd0, 0, 0);
        step(0, 32'h0, 0, 0, 5'd0, 1, 0);
        #2;
        check_val("flush_out_valid", out_valid, 0);
        repeat (2) step(1, I_ADD_X6, 1, 0, 5'd0, 0, 0);
        step(1, I_ADD_X6, 1, 1, 5'd5, 0, 0);
        step(1, I_ADD_X6, 1, 0, 5'd0, 0, 0);
        drain();

        // Set beats clear for the same register
        step(1, I_LW_X7, 1, 1, 5'd7, 0, 0);
        repeat (2) step(1, I_ADD_X9, 1, 0, 5'd0, 0, 0);
        step(1, I_ADD_X9, 1, 1, 5'd7, 0, 0);
        step(1, I_ADD_X9, 1, 0, 5'd0, 0, 0);
        drain();

        // M extension
        step(1, I_MUL_X8, 1, 0, 5'd0, 0, 0);
        #2;
`ifdef DECODE_STAGE_MEXT_EN
        check_val("mul_alu", funct_alu, 5'h10);
        check_val("mul_illegal", decoded_op_de[13], 0);
`else
        check_val("mul_illegal", decoded_op_de[13], 1);
        check_val("mul_rd", rdsel_de, 0);
`endif
        drain();

        // Reset with flush during full buffer and stall
        step(1, I_LW_X5, 0, 0, 5'd0, 0, 0);
        step(1, I_ADDI_X1, 0, 0, 5'd0, 0, 0);
        step(1, I_ADD_X6, 0, 0, 5'd0, 0, 0);
        step(0, 32'h0, 0, 0, 5'd0, 1, 1);
        step(1, I_ADD_X6, 1, 0, 5'd0, 0, 0);
        drain();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
                 $urandom_range(0, 24) == 0, $urandom_range(0, 199) == 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
